// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART controller: register indices, STATUS and
// CTRL bit positions, the TX sequencer state encoding and the busy timeout.
// No ports (package).
// ----------------------------------------------------------------------------
package uart_pkg;

    // Register index, taken from bus_addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_TX_IDLE     = 4;
    localparam int ST_RX_OVF      = 5;
    localparam int ST_TX_OVF      = 6;

    // CTRL bit positions (bits 5/6 are write-1-to-clear strobes)
    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TX_IRQ_EN  = 1;
    localparam int CTRL_CLR_RX_OVF = 5;
    localparam int CTRL_CLR_TX_OVF = 6;

    // TX sequencer states
    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LAUNCH    = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_t;

    // Cycles spent in TX_WAIT_BUSY before giving up on the transmitter
    localparam int TX_BUSY_TIMEOUT = 4;
    localparam int TX_TMO_W        = 3;

endpackage

// File: rtl/uart_fifo.sv
// ----------------------------------------------------------------------------
// uart_fifo
// Synchronous show-ahead FIFO. Pointers are AW+1 bits and wrap naturally;
// the extra MSB distinguishes full from empty.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_push, i_din    write request and data (ignored when full unless a
//                    pop happens in the same cycle)
//   i_pop            read request (ignored when empty)
//   o_dout           head entry, valid while o_empty=0
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when it coincides with a pop.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// ----------------------------------------------------------------------------
// uart_ctrl
// Memory-mapped UART controller between the peripheral bus and an external
// async transmitter/receiver pair. Buffers bytes in a TX and an RX FIFO,
// sequences the transmitter start/busy handshake, keeps sticky overflow
// flags and drives a registered level interrupt.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bus_en, bus_we, bus_addr   one-cycle access strobe, direction, address
//   bus_wdata / bus_rdata      write data / registered read data
//   tx_start, tx_data, tx_busy transmitter handshake
//   rx_ready, rx_data          receiver byte strobe and data
//   irq                        level interrupt
// ----------------------------------------------------------------------------
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_en,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        irq
);

    logic [1:0]         w_sel;
    logic               w_rd;
    logic               w_wr;
    logic               w_ctrl_wr;

    logic               w_rx_pop;
    logic [7:0]         w_rx_dout;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic [FIFO_AW:0]   w_rx_count;

    logic               w_tx_push;
    logic               w_tx_pop;
    logic [7:0]         w_tx_dout;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [FIFO_AW:0]   w_tx_count;
    logic               w_tx_idle;

    tx_state_t          r_state;
    tx_state_t          w_next;
    logic               w_tx_start;
    logic [TX_TMO_W-1:0] r_tmo;
    logic [7:0]         r_tx_data;

    logic               r_rx_irq_en;
    logic               r_tx_irq_en;
    logic               r_rx_ovf;
    logic               r_tx_ovf;
    logic               w_rx_ovf_set;
    logic               w_tx_ovf_set;

    logic [31:0]        w_rdata_nxt;
    logic [31:0]        r_rdata;
    logic               r_irq;
    logic               w_unused_bits;

    assign w_sel     = bus_addr[3:2];
    assign w_rd      = bus_en & ~bus_we;
    assign w_wr      = bus_en &  bus_we;
    assign w_ctrl_wr = w_wr & (w_sel == REG_CTRL);

    assign w_unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    assign w_rx_pop  = w_rd & (w_sel == REG_DATA);
    assign w_tx_push = w_wr & (w_sel == REG_DATA);

    uart_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .DW(8)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (rx_ready),
        .i_din   (rx_data),
        .i_pop   (w_rx_pop),
        .o_dout  (w_rx_dout),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .DW(8)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_tx_push),
        .i_din   (bus_wdata[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    // ------------------------------------------------------------------
    // TX sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= TX_IDLE;
            r_tmo     <= '0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_tx_pop) r_tx_data <= w_tx_dout;
            // Counts cycles spent waiting for busy; cleared in every other state.
            if (r_state == TX_WAIT_BUSY) r_tmo <= r_tmo + 1'b1;
            else                         r_tmo <= '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_tx_pop   = 1'b0;
        w_tx_start = 1'b0;
        case (r_state)
            TX_IDLE: begin
                // Also covers the first launch after reset: the transmitter
                // may still be finishing a frame this block aborted.
                if (!w_tx_empty && !tx_busy) begin
                    w_tx_pop = 1'b1;
                    w_next   = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                w_tx_start = 1'b1;
                w_next     = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy)
                    w_next = TX_WAIT_DONE;
                else if (r_tmo == TX_TMO_W'(TX_BUSY_TIMEOUT - 1))
                    w_next = TX_IDLE;
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) w_next = TX_IDLE;
            end
            default: w_next = TX_IDLE;
        endcase
    end

    assign tx_start  = w_tx_start;
    assign tx_data   = r_tx_data;
    assign w_tx_idle = w_tx_empty & (r_state == TX_IDLE);

    // ------------------------------------------------------------------
    // Control register and sticky overflow flags
    // ------------------------------------------------------------------
    // A full FIFO is never empty, so a pop request there always frees a slot.
    assign w_rx_ovf_set = rx_ready  & w_rx_full & ~w_rx_pop;
    assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_tx_ovf    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_rx_irq_en <= bus_wdata[CTRL_RX_IRQ_EN];
                r_tx_irq_en <= bus_wdata[CTRL_TX_IRQ_EN];
            end
            // A new overflow wins over a clear in the same cycle so no event is lost.
            if (w_rx_ovf_set)
                r_rx_ovf <= 1'b1;
            else if (w_ctrl_wr && bus_wdata[CTRL_CLR_RX_OVF])
                r_rx_ovf <= 1'b0;
            if (w_tx_ovf_set)
                r_tx_ovf <= 1'b1;
            else if (w_ctrl_wr && bus_wdata[CTRL_CLR_TX_OVF])
                r_tx_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read data and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_nxt = '0;
        case (w_sel)
            REG_DATA: begin
                if (!w_rx_empty) w_rdata_nxt[7:0] = w_rx_dout;
            end
            REG_STATUS: begin
                w_rdata_nxt[ST_RX_NONEMPTY] = ~w_rx_empty;
                w_rdata_nxt[ST_RX_FULL]     = w_rx_full;
                w_rdata_nxt[ST_TX_EMPTY]    = w_tx_empty;
                w_rdata_nxt[ST_TX_FULL]     = w_tx_full;
                w_rdata_nxt[ST_TX_IDLE]     = w_tx_idle;
                w_rdata_nxt[ST_RX_OVF]      = r_rx_ovf;
                w_rdata_nxt[ST_TX_OVF]      = r_tx_ovf;
            end
            REG_CTRL: begin
                w_rdata_nxt[CTRL_RX_IRQ_EN] = r_rx_irq_en;
                w_rdata_nxt[CTRL_TX_IRQ_EN] = r_tx_irq_en;
            end
            REG_LEVEL: begin
                w_rdata_nxt[FIFO_AW:0]       = w_rx_count;
                w_rdata_nxt[16+FIFO_AW:16]   = w_tx_count;
            end
            default: w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_rd) r_rdata <= w_rdata_nxt;
            r_irq <= (r_rx_irq_en & ~w_rx_empty) |
                     (r_tx_irq_en & w_tx_idle)   |
                     r_rx_ovf | r_tx_ovf;
        end
    end

    assign bus_rdata = r_rdata;
    assign irq       = r_irq;

endmodule

// File: tb/tb_uart_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_ctrl
// Scoreboard bench for uart_ctrl. Stimulus tasks update a queue-based model
// of the controller and push expected bus reads and expected transmitted
// bytes; independent monitors pop and compare when the DUT produces them.
// ----------------------------------------------------------------------------
module tb_uart_ctrl;

    localparam int DEPTH = 16;
    localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_LEVEL = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_en = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        irq;

    logic        hold_busy = 1'b0;
    logic        m_busy = 1'b0;
    bit          model_en = 1'b1;
    assign tx_busy = hold_busy | m_busy;

    uart_ctrl #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_rx[$];
    int          m_tx_cnt = 0;
    bit          m_rx_ovf = 0, m_tx_ovf = 0, m_rx_en = 0, m_tx_en = 0;

    // Scoreboard queues
    logic [31:0] exp_rd_q[$];
    string       exp_nm_q[$];
    logic [7:0]  exp_tx_q[$];

    int cyc = 0;
    int n_starts = 0;
    int last_start = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model views (tx_idle is only queried once the transmitter is quiet)
    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = (m_rx.size() != 0);
        s[1] = (m_rx.size() == DEPTH);
        s[2] = (m_tx_cnt == 0);
        s[3] = (m_tx_cnt == DEPTH);
        s[4] = (m_tx_cnt == 0);
        s[5] = m_rx_ovf;
        s[6] = m_tx_ovf;
        return s;
    endfunction

    function automatic logic [31:0] m_level();
        return (32'(m_tx_cnt) << 16) | 32'(m_rx.size());
    endfunction

    function automatic logic m_irq();
        return (m_rx_en && m_rx.size() != 0) || (m_tx_en && m_tx_cnt == 0) || m_rx_ovf || m_tx_ovf;
    endfunction

    // Transmitter model: busy rises one cycle after start, lasts 20 cycles
    always @(negedge clk) begin
        if (tx_start && model_en) begin
            @(negedge clk);
            m_busy = 1'b1;
            repeat (20) @(negedge clk);
            m_busy = 1'b0;
        end
    end

    // TX monitor
    always @(negedge clk) begin
        if (tx_start) begin
            n_starts++;
            if (exp_tx_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL tx_unexpected: got tx_data=0x%02h, expected no launch", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
            end
            if (m_tx_cnt > 0) m_tx_cnt--;
            if (last_start >= 0)
                check("tx_start_spacing_ge22", 32'(cyc - last_start >= 22), 32'd1);
            last_start = cyc;
        end
    end

    // Bus read monitor
    always @(posedge clk) begin
        if (rst_n && bus_en && !bus_we) begin
            @(negedge clk);
            if (exp_rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL read_unexpected: got 0x%0h, expected no read", bus_rdata);
            end else begin
                check(exp_nm_q.pop_front(), bus_rdata, exp_rd_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = {r, 2'($urandom)}; bus_wdata = d;
        @(negedge clk);
        bus_en = 1'b0; bus_we = 1'b0; bus_wdata = $urandom;
    endtask

    task automatic bus_read(input logic [1:0] r, input logic [31:0] exp, input string nm);
        exp_rd_q.push_back(exp);
        exp_nm_q.push_back(nm);
        @(negedge clk);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = {r, 2'($urandom)};
        @(negedge clk);
        bus_en = 1'b0;
    endtask

    task automatic read_data(input string nm);
        logic [31:0] e;
        e = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
        bus_read(R_DATA, e, nm);
    endtask

    task automatic m_write(input logic [7:0] b);
        if (m_tx_cnt < DEPTH) begin
            m_tx_cnt++;
            exp_tx_q.push_back(b);
        end else begin
            m_tx_ovf = 1'b1;
        end
        bus_write(R_DATA, {24'h0, b});
    endtask

    task automatic rx_push(input logic [7:0] b);
        if (m_rx.size() < DEPTH) m_rx.push_back(b);
        else m_rx_ovf = 1'b1;
        @(negedge clk);
        rx_ready = 1'b1; rx_data = b;
        @(negedge clk);
        rx_ready = 1'b0; rx_data = $urandom;
    endtask

    task automatic wait_tx_idle(input int limit);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < limit) begin
            @(negedge clk);
            n++;
            if (exp_tx_q.size() == 0 && !tx_busy && !tx_start) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++; failures++;
            $display("FAIL tx_drain_timeout: got %0d bytes pending, expected 0", exp_tx_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(input int limit);
        int snap = n_starts;
        int n = 0;
        while (n_starts == snap && n < limit) begin @(negedge clk); n++; end
        if (n_starts == snap) begin
            checks++; failures++;
            $display("FAIL tx_start_timeout: got no start, expected one within %0d cycles", limit);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int n;
        int snap;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rdata", bus_rdata, 0);
        check("reset_tx_start", {31'h0, tx_start}, 0);
        check("reset_tx_data", {24'h0, tx_data}, 0);
        check("reset_irq", {31'h0, irq}, 0);
        rst_n = 1'b1;
        bus_read(R_STATUS, m_status(), "reset_status");
        bus_read(R_LEVEL, m_level(), "reset_level");
        bus_read(R_CTRL, 32'h0, "reset_ctrl");

        // 1: ordered transmission, then a random burst, then a busy timeout
        m_write(8'h41); m_write(8'h42); m_write(8'h43);
        wait_tx_idle(400);
        bus_read(R_STATUS, m_status(), "t1_status_idle");
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) m_write(8'($urandom));
        wait_tx_idle(600);
        model_en = 1'b0;
        m_write(8'hE7);
        wait_tx_idle(100);
        bus_read(R_STATUS, m_status(), "t1_status_after_timeout");
        model_en = 1'b1;

        // 2: RX path, fixed then random
        rx_push(8'h55); rx_push(8'hAA);
        bus_read(R_LEVEL, m_level(), "t2_level_2");
        read_data("t2_read_55"); read_data("t2_read_aa"); read_data("t2_read_empty");
        bus_read(R_LEVEL, m_level(), "t2_level_0");
        n = $urandom_range(3, 12);
        for (int i = 0; i < n; i++) begin
            rx_push(8'($urandom));
            if ($urandom_range(0, 2) == 0) read_data("t2_rand_read");
        end
        bus_read(R_LEVEL, m_level(), "t2_rand_level");
        while (m_rx.size() != 0) read_data("t2_drain");
        read_data("t2_drain_empty");

        // 3: TX overflow with the transmitter held busy
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) m_write(8'($urandom));
        bus_read(R_STATUS, m_status(), "t3_status_full_ovf");
        bus_read(R_LEVEL, m_level(), "t3_level_16");
        repeat (2) @(negedge clk);
        check("t3_irq_ovf", {31'h0, irq}, {31'h0, m_irq()});
        bus_write(R_CTRL, 32'h40);
        m_tx_ovf = 1'b0;
        check("t3_irq_still_set", {31'h0, irq}, 1);
        @(negedge clk);
        check("t3_irq_dropped", {31'h0, irq}, {31'h0, m_irq()});
        hold_busy = 1'b0;
        wait_tx_idle(1000);
        bus_read(R_STATUS, m_status(), "t3_status_drained");

        // 4: RX full with simultaneous push and pop, then overflow
        for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
        bus_read(R_LEVEL, m_level(), "t4_level_16");
        b = 8'($urandom);
        exp_rd_q.push_back({24'h0, m_rx.pop_front()});
        exp_nm_q.push_back("t4_simul_read_oldest");
        m_rx.push_back(b);
        @(negedge clk);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = {R_DATA, 2'b00};
        rx_ready = 1'b1; rx_data = b;
        @(negedge clk);
        bus_en = 1'b0; rx_ready = 1'b0;
        bus_read(R_LEVEL, m_level(), "t4_level_still_16");
        bus_read(R_STATUS, m_status(), "t4_status_no_ovf");
        rx_push(8'($urandom));
        bus_read(R_STATUS, m_status(), "t4_status_ovf");
        repeat (2) @(negedge clk);
        check("t4_irq_rx_ovf", {31'h0, irq}, {31'h0, m_irq()});
        bus_write(R_CTRL, 32'h20);
        m_rx_ovf = 1'b0;
        while (m_rx.size() != 0) read_data("t4_drain");
        bus_read(R_STATUS, m_status(), "t4_status_clear");

        // 5: interrupt timing
        bus_write(R_CTRL, 32'h1);
        m_rx_en = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_irq_idle", {31'h0, irq}, {31'h0, m_irq()});
        rx_push(8'h10);
        check("t5_irq_1cyc", {31'h0, irq}, 0);
        @(negedge clk);
        check("t5_irq_2cyc", {31'h0, irq}, 1);
        read_data("t5_read_10");
        check("t5_irq_before_drop", {31'h0, irq}, 1);
        @(negedge clk);
        check("t5_irq_after_read", {31'h0, irq}, {31'h0, m_irq()});
        bus_write(R_CTRL, 32'h2);
        m_rx_en = 1'b0; m_tx_en = 1'b1;
        bus_read(R_CTRL, {30'h0, m_tx_en, m_rx_en}, "t5_ctrl_readback");
        repeat (2) @(negedge clk);
        check("t5_irq_tx_idle", {31'h0, irq}, {31'h0, m_irq()});
        bus_write(R_CTRL, 32'h0);
        m_tx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_irq_off", {31'h0, irq}, {31'h0, m_irq()});

        // 6: asynchronous reset during WAIT_DONE
        bus_write(R_CTRL, 32'h1);
        m_rx_en = 1'b1;
        rx_push(8'h77);
        m_write(8'hC3); m_write(8'h3C);
        wait_start(200);
        repeat (6) @(negedge clk);
        bus_read(R_LEVEL, m_level(), "t6_level_before_reset");
        check("t6_irq_before_reset", {31'h0, irq}, {31'h0, m_irq()});
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tx_start", {31'h0, tx_start}, 0);
        check("t6_rst_irq", {31'h0, irq}, 0);
        check("t6_rst_rdata", bus_rdata, 0);
        check("t6_rst_tx_data", {24'h0, tx_data}, 0);
        exp_tx_q.delete(); m_tx_cnt = 0; m_rx.delete();
        m_rx_ovf = 0; m_tx_ovf = 0; m_rx_en = 0; m_tx_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(R_LEVEL, m_level(), "t6_level_after_reset");
        bus_read(R_STATUS, m_status(), "t6_status_after_reset");
        snap = n_starts;
        m_write(8'h5A);
        n = 0;
        while (tx_busy && n < 100) begin @(negedge clk); n++; end
        check("t6_launch_waits_busy", 32'(n_starts), 32'(snap));
        wait_tx_idle(200);

        repeat (4) @(negedge clk);
        check("end_reads_consumed", 32'(exp_rd_q.size()), 0);
        check("end_tx_consumed", 32'(exp_tx_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
